// File: rtl/lift_pkg.sv
// lift_pkg: shared types and helpers for the lift call scheduler.
//   floor_t        - 2-bit floor index, floors 1..4 encoded 0..3
//   U1..D4         - bit positions of the hall-call buttons in button_in/pending
//   sched_state_t  - scheduler FSM states
//   DIR_UP/DIR_DOWN- scan direction encodings
//   floor_mask()   - collapse the 6 button bits into a per-floor request mask
//   floor_buttons()- the button bits that belong to one floor
package lift_pkg;

  localparam int N_FLOORS = 4;

  typedef logic [1:0] floor_t;

  localparam int U1 = 0;
  localparam int U2 = 1;
  localparam int U3 = 2;
  localparam int D2 = 3;
  localparam int D3 = 4;
  localparam int D4 = 5;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_DISPATCH = 3'd2,
    S_WAIT     = 3'd3,
    S_CLEAR    = 3'd4,
    S_FAULT    = 3'd5
  } sched_state_t;

  // A floor is requested if either of its buttons is latched.
  function automatic logic [N_FLOORS-1:0] floor_mask(input logic [5:0] b);
    return {b[D4], b[U3] | b[D3], b[U2] | b[D2], b[U1]};
  endfunction

  // Arrival at a floor services both of its buttons.
  function automatic logic [5:0] floor_buttons(input floor_t f);
    logic [5:0] m;
    m = '0;
    case (f)
      2'd0: m[U1] = 1'b1;
      2'd1: begin m[U2] = 1'b1; m[D2] = 1'b1; end
      2'd2: begin m[U3] = 1'b1; m[D3] = 1'b1; end
      default: m[D4] = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lift_floor_picker.sv
// lift_floor_picker: combinational SCAN selection.
//   f_mask    in  per-floor request mask
//   cur_floor in  current lift position
//   dir_up    in  current scan direction (1=up)
//   found     out a floor other than cur_floor is requested
//   pick      out nearest requested floor, ahead first, behind on reversal
//   new_dir   out direction after the pick (flips only on reversal)
//   here      out cur_floor itself is requested
module lift_floor_picker
  import lift_pkg::*;
(
  input  logic [N_FLOORS-1:0] f_mask,
  input  floor_t              cur_floor,
  input  logic                dir_up,
  output logic                found,
  output floor_t              pick,
  output logic                new_dir,
  output logic                here
);

  logic   up_found, dn_found;
  floor_t up_pick, dn_pick;

  // Nearest above: scan downward so the last hit is the smallest floor.
  always_comb begin
    up_found = 1'b0;
    up_pick  = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (f_mask[i] && (floor_t'(i) > cur_floor)) begin
        up_found = 1'b1;
        up_pick  = floor_t'(i);
      end
    end
  end

  // Nearest below: scan upward so the last hit is the largest floor.
  always_comb begin
    dn_found = 1'b0;
    dn_pick  = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (f_mask[i] && (floor_t'(i) < cur_floor)) begin
        dn_found = 1'b1;
        dn_pick  = floor_t'(i);
      end
    end
  end

  always_comb begin
    found   = up_found | dn_found;
    pick    = '0;
    new_dir = dir_up;
    if (dir_up) begin
      if (up_found)      begin pick = up_pick; new_dir = DIR_UP;   end
      else if (dn_found) begin pick = dn_pick; new_dir = DIR_DOWN; end
    end else begin
      if (dn_found)      begin pick = dn_pick; new_dir = DIR_DOWN; end
      else if (up_found) begin pick = up_pick; new_dir = DIR_UP;   end
    end
  end

  assign here = f_mask[cur_floor];

endmodule

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: SCAN-ordered hall-call scheduler feeding the lift FSM.
// Calls latch into `pending`; the nearest floor ahead in the current direction
// is dispatched over target_valid/target_ready, then the block waits for done.
// A watchdog in WAIT raises a sticky fault if done never arrives.
//   clk, rst_n     clock, async active-low reset
//   button_in[5:0] hall-call pulses (u1,u2,u3,d2,d3,d4)
//   cur_floor[1:0] lift position
//   done           lift arrived at last accepted target
//   target_ready   lift FSM accepts target
//   target[1:0], target_valid  dispatched floor and its valid
//   dir_up         scan direction
//   pending[5:0]   latched calls
//   busy           not in IDLE/FAULT
//   fault          sticky watchdog error
// Optional: define LIFT_SCHED_HOME_EN to park at HOME_FLOOR after HOME_DELAY
// idle cycles away from it.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [1:0]  HOME_FLOOR     = 2'd0,
  parameter int unsigned HOME_DELAY     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] button_in,
  input  logic [1:0] cur_floor,
  input  logic       done,
  input  logic       target_ready,
  output logic [1:0] target,
  output logic       target_valid,
  output logic       dir_up,
  output logic [5:0] pending,
  output logic       busy,
  output logic       fault
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  sched_state_t        state;
  floor_t              clr_floor;
  logic [5:0]          clr_mask;
  logic [N_FLOORS-1:0] fmask;
  logic                pk_found, pk_dir, pk_here;
  floor_t              pk_pick;
  logic [WD_W-1:0]     wd_cnt, wd_nxt;
  logic                parking;
  logic                park_go;

  assign fmask = floor_mask(pending);

  lift_floor_picker u_pick (
    .f_mask   (fmask),
    .cur_floor(cur_floor),
    .dir_up   (dir_up),
    .found    (pk_found),
    .pick     (pk_pick),
    .new_dir  (pk_dir),
    .here     (pk_here)
  );

  assign clr_mask = (state == S_CLEAR) ? floor_buttons(clr_floor) : '0;
  assign busy     = (state != S_IDLE) && (state != S_FAULT);
  assign wd_nxt   = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 1'b1;

  // New presses win over the clear of the same bit; latching never stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | button_in;
  end

`ifdef LIFT_SCHED_HOME_EN
  localparam int ID_W = $clog2(HOME_DELAY + 1);
  localparam logic [ID_W-1:0] HD_M1 = ID_W'(HOME_DELAY - 1);

  logic [ID_W-1:0] idle_cnt;
  logic            idle_away;

  assign idle_away = (state == S_IDLE) && (pending == '0) && (button_in == '0) &&
                     (cur_floor != HOME_FLOOR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          idle_cnt <= '0;
    else if (!idle_away) idle_cnt <= '0;
    else if (!park_go)   idle_cnt <= idle_cnt + 1'b1;
  end

  // Fires on the HOME_DELAY-th consecutive idle cycle away from home.
  assign park_go = idle_away && (idle_cnt == HD_M1);
`else
  logic unused_home;
  assign unused_home = ^{HOME_FLOOR, 32'(HOME_DELAY)};
  assign park_go     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      target       <= '0;
      target_valid <= 1'b0;
      dir_up       <= DIR_UP;
      fault        <= 1'b0;
      wd_cnt       <= '0;
      clr_floor    <= '0;
      parking      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending != '0) begin
            state <= S_SELECT;
          end else if (park_go) begin
            target       <= HOME_FLOOR;
            target_valid <= 1'b1;
            parking      <= 1'b1;
            state        <= S_DISPATCH;
          end
        end
        S_SELECT: begin
          if (pk_found) begin
            target       <= pk_pick;
            dir_up       <= pk_dir;
            target_valid <= 1'b1;
            parking      <= 1'b0;
            state        <= S_DISPATCH;
          end else if (pk_here) begin
            clr_floor <= cur_floor;
            state     <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DISPATCH: begin
          if (target_ready) begin
            target_valid <= 1'b0;
            wd_cnt       <= '0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            wd_cnt <= '0;
            // A park is not a call: arrival services no buttons.
            if (parking) begin
              parking <= 1'b0;
              state   <= S_SELECT;
            end else begin
              clr_floor <= target;
              state     <= S_CLEAR;
            end
          end else begin
            wd_cnt <= wd_nxt;
            if (wd_nxt == WD_MAX) begin
              fault <= 1'b1;
              state <= S_FAULT;
            end
          end
        end
        S_CLEAR: state <= S_SELECT;
        S_FAULT: begin
          fault        <= 1'b1;
          target_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_call_scheduler.sv
module tb_lift_call_scheduler;
  import lift_pkg::*;

  localparam int TMO  = 8;
  localparam int HDLY = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] button_in = '0;
  logic [1:0] cur_floor = '0;
  logic       done = 1'b0;
  logic       target_ready = 1'b0;
  logic [1:0] target;
  logic       target_valid, dir_up, busy, fault;
  logic [5:0] pending;

  always #5 clk = ~clk;

  lift_call_scheduler #(.TIMEOUT_CYCLES(TMO), .HOME_FLOOR(2'd0), .HOME_DELAY(HDLY)) dut (
    .clk(clk), .rst_n(rst_n), .button_in(button_in), .cur_floor(cur_floor),
    .done(done), .target_ready(target_ready), .target(target),
    .target_valid(target_valid), .dir_up(dir_up), .pending(pending),
    .busy(busy), .fault(fault)
  );

  typedef struct packed {logic [1:0] tgt; logic dir;} disp_t;
  typedef struct {
    logic [1:0] cur;
    logic [5:0] btn;
    logic       disp;
    logic [1:0] tgt;
    logic       dir;
  } vec_t;

  disp_t sb[$];
  vec_t  tbl[10];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; a handshake seen just before the edge is scored against the queue.
  task automatic cyc();
    logic  hs;
    disp_t got, e;
    hs  = target_valid && target_ready;
    got = '{target, dir_up};
    @(posedge clk); #1;
    if (hs) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_dispatch: got target %0d with nothing expected", got.tgt);
      end else begin
        e = sb.pop_front();
        chk("disp_target", got.tgt, e.tgt);
        chk("disp_dir", got.dir, e.dir);
      end
    end
  endtask

  task automatic serve(input logic [1:0] f);
    cur_floor = f;
    cyc();
    done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 12) begin cyc(); k++; end
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int saw;
    tbl[0] = '{2'd0, 6'b000100, 1'b1, 2'd2, 1'b1};
    tbl[1] = '{2'd2, 6'b000001, 1'b1, 2'd0, 1'b0};
    tbl[2] = '{2'd0, 6'b100000, 1'b1, 2'd3, 1'b1};
    tbl[3] = '{2'd3, 6'b001000, 1'b1, 2'd1, 1'b0};
    tbl[4] = '{2'd1, 6'b010000, 1'b1, 2'd2, 1'b1};
    tbl[5] = '{2'd2, 6'b010000, 1'b0, 2'd0, 1'b1};
    tbl[6] = '{2'd3, 6'b000001, 1'b1, 2'd0, 1'b0};
    tbl[7] = '{2'd0, 6'b000001, 1'b0, 2'd0, 1'b0};
    tbl[8] = '{2'd1, 6'b001010, 1'b0, 2'd0, 1'b0};
    tbl[9] = '{2'd1, 6'b000100, 1'b1, 2'd2, 1'b1};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_target", target, 0);
    chk("rst_valid", target_valid, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-call table: latency, direction, here-only clear
    for (int i = 0; i < 10; i++) begin
      cur_floor = tbl[i].cur;
      button_in = tbl[i].btn;
      cyc();
      button_in = '0;
      chk("latch", pending, tbl[i].btn);
      cyc();
      chk("e1_valid", target_valid, 0);
      cyc();
      chk("e2_valid", target_valid, tbl[i].disp);
      if (tbl[i].disp) begin
        sb.push_back('{tbl[i].tgt, tbl[i].dir});
        target_ready = 1'b1;
        cyc();
        target_ready = 1'b0;
        chk("drop_valid", target_valid, 0);
        serve(tbl[i].tgt);
      end else begin
        cyc();
        chk("here_clear", pending, 0);
      end
      wait_idle();
      chk("end_pending", pending, 0);
    end

    // Two calls at once, arrival cost, backpressure hold
    cur_floor = 2'd0;
    button_in = 6'b100010;
    cyc();
    button_in = '0;
    cyc();
    cyc();
    chk("multi_e2_valid", target_valid, 1);
    chk("multi_e2_target", target, 1);
    sb.push_back('{2'd1, 1'b1});
    target_ready = 1'b1;
    cyc();
    target_ready = 1'b0;
    serve(2'd1);
    cyc();
    chk("arrive_gap_valid", target_valid, 0);
    cyc();
    chk("second_valid", target_valid, 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_valid", target_valid, 1);
      chk("hold_target", target, 3);
    end
    sb.push_back('{2'd3, 1'b1});
    target_ready = 1'b1;
    cyc();
    target_ready = 1'b0;
    chk("accept_drop", target_valid, 0);
    serve(2'd3);
    wait_idle();
    chk("multi_pending", pending, 0);

    // Watchdog
    button_in = 6'b000010;
    cyc();
    button_in = '0;
    cyc();
    cyc();
    sb.push_back('{2'd1, 1'b0});
    target_ready = 1'b1;
    cyc();
    target_ready = 1'b0;
    repeat (TMO - 1) cyc();
    chk("wd_early_fault", fault, 0);
    chk("wd_early_busy", busy, 1);
    cyc();
    chk("wd_fault", fault, 1);
    chk("wd_busy", busy, 0);
    button_in = 6'b100000;
    cyc();
    button_in = '0;
    chk("fault_latch", pending, 6'b100010);
    done = 1'b1;
    cyc();
    done = 1'b0;
    saw = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (target_valid) saw++;
    end
    chk("fault_no_valid", saw, 0);
    chk("fault_sticky", fault, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fault", fault, 0);
    chk("arst_pending", pending, 0);
    chk("arst_dir", dir_up, 1);
    chk("arst_target", target, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef LIFT_SCHED_HOME_EN
    cur_floor = 2'd0;
    cyc();
    cur_floor = 2'd2;
    repeat (HDLY - 1) cyc();
    chk("park_early", target_valid, 0);
    cyc();
    chk("park_valid", target_valid, 1);
    chk("park_target", target, 0);
    sb.push_back('{2'd0, 1'b1});
    target_ready = 1'b1;
    cyc();
    target_ready = 1'b0;
    serve(2'd0);
    wait_idle();
    chk("park_pending", pending, 0);
`else
    cur_floor = 2'd2;
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (target_valid || busy) saw++;
    end
    chk("idle_stays", saw, 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lift_call_scheduler.md
Name: lift_call_scheduler

Overview:
- SCAN-style call scheduler placed between the six hall-call buttons and the lift FSM.
- Replaces FIFO ordering: latches calls into a pending register and picks the nearest pending floor in the current travel direction, reversing only when nothing remains ahead.
- Hands targets to the lift FSM over a valid/ready handshake, then waits for the lift's done pulse.
- Watchdog flags a lift that never reports arrival.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in WAIT without done before fault.
- HOME_FLOOR, 0: park floor, 2-bit encoding; used only with the optional feature.
- HOME_DELAY, 64: idle cycles before a park dispatch; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- button_in  in  6  hall-call pulses; bit0=u1, bit1=u2, bit2=u3, bit3=d2, bit4=d3, bit5=d4.
- cur_floor  in  2  lift position; floors 1..4 encoded 0..3.
- done  in  1  one-cycle pulse when the lift reaches the last accepted target.
- target_ready  in  1  lift FSM accepts a target.
- target  out  2  dispatched floor.
- target_valid  out  1  target offered.
- dir_up  out  1  current scan direction; 1=up.
- pending  out  6  latched call register, same bit order as button_in.
- busy  out  1  high in any state other than IDLE and FAULT.
- fault  out  1  sticky watchdog error.

Behaviour:
- Reset is asynchronous and active-low. On reset: target=0, target_valid=0, dir_up=1, pending=0, busy=0, fault=0, FSM=IDLE, counters=0. Reset asserted mid-operation aborts immediately and drops all pending calls.
- Pending register: pending <= (pending & ~clr_mask) | button_in every cycle. Set wins over clear for the same bit. Latching continues in every state, including FAULT.
- Floor mask: F0=b0; F1=b1|b3; F2=b2|b4; F3=b5.
- Selection, evaluated in SELECT:
  - If dir_up: take the smallest f>cur_floor with F[f]. Otherwise take the largest f<cur_floor with F[f] and set dir_up<=0.
  - If dir_down: mirror of the above; the reversal sets dir_up<=1.
  - If only F[cur_floor] is set: go to CLEAR without dispatching.
  - If F is empty: return to IDLE.
- FSM states: IDLE, SELECT, DISPATCH, WAIT, CLEAR, FAULT.
  - IDLE -> SELECT when pending!=0.
  - SELECT -> DISPATCH, CLEAR or IDLE according to the selection rules.
  - DISPATCH: target_valid=1 with target held stable until the edge where target_ready=1, then -> WAIT. target_valid deasserts on that edge.
  - WAIT: watchdog counts from 0. done -> CLEAR. If the count reaches TIMEOUT_CYCLES with no done -> FAULT.
  - CLEAR: one cycle; clr_mask = both buttons of the arrived floor (cur_floor when entered from SELECT, target when entered from WAIT); -> SELECT.
  - FAULT: fault=1, target_valid=0, no dispatch; exits only via rst_n.
- done is ignored outside WAIT.
- Latency: button pulse sampled at edge E0 sets pending at E0. SELECT is entered at E1 and target_valid rises at E2. Each arrival costs 2 cycles (CLEAR, SELECT) before the next dispatch.
- Widths: floor compares are unsigned 2-bit. The watchdog counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates.

Optional Feature:
- Macro: LIFT_SCHED_HOME_EN.
- Enabled: in IDLE, an idle counter increments while pending==0 and cur_floor!=HOME_FLOOR. When it reaches HOME_DELAY, the block dispatches HOME_FLOOR through DISPATCH/WAIT with normal watchdog and handshake. The park does not clear any pending bits. Any button press resets the idle counter.
- Disabled: no idle counter; IDLE waits indefinitely.

Decomposition:
- Package lift_pkg:
  - floor_t (2-bit) and button index constants U1..D4.
  - sched_state_t enum.
  - DIR_UP/DIR_DOWN constants.
  - N_FLOORS=4.
- Sub-module lift_floor_picker: combinational; inputs F[3:0], cur_floor, dir_up; outputs found, pick, new_dir, here.

Test Plan:
- cur_floor=0, pulse bit1 (u2) and bit5 (d4) together -> target_valid at E2 with target=1. After done, target=3 with dir_up=1. After the second done, pending=0 and busy=0.
- cur_floor=3, dir_up=1, pulse bit0 (u1) -> SELECT reverses: dir_up=0, target=0.
- cur_floor=2, idle, pulse bit2 (u3) -> pending[2] clears within 3 cycles and target_valid never rises.
- Hold target_ready=0 for 5 cycles during DISPATCH -> target_valid stays 1 and target stays constant. Accept on the cycle ready rises; the next cycle target_valid=0.
- TIMEOUT_CYCLES=8, withhold done -> fault=1 after 8 cycles in WAIT. Later button presses still set pending but target_valid stays 0. rst_n pulse clears everything.
- With LIFT_SCHED_HOME_EN, HOME_DELAY=4, cur_floor=2, no calls -> target=0 dispatched after 4 idle cycles.
